// File: rtl/codec_i2c_target_pkg.sv
// Shared types and constants for the codec-side I2C control port.
// Holds the device address, register map, shadow reset image and target FSM states.
package audio_codec_pkg;

    localparam logic [6:0] CODEC_DEV_ADDR = 7'h1A;

    typedef enum logic [6:0] {
        RegLinvol  = 7'd0,
        RegRinvol  = 7'd1,
        RegLoutvol = 7'd2,
        RegRoutvol = 7'd3,
        RegApana   = 7'd4,
        RegDpath   = 7'd5,
        RegPwrdn   = 7'd6,
        RegDaif    = 7'd7,
        RegSrate   = 7'd8,
        RegActive  = 7'd9,
        RegReset   = 7'd15
    } codec_reg_e;

    // Index 0 is the rightmost element.
    localparam logic [15:0][8:0] RESET_DEFAULTS = {
        9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000,
        9'h000, 9'h000, 9'h00A, 9'h09F, 9'h008, 9'h00A,
        9'h079, 9'h079, 9'h097, 9'h097
    };

    typedef enum logic [2:0] {
        TgtIdle,
        TgtAddr,
        TgtAddrAck,
        TgtByte0,
        TgtAck0,
        TgtByte1,
        TgtAck1,
        TgtIgnore
    } i2c_tgt_state_e;

    function automatic logic [8:0] reset_default(input int unsigned idx);
        logic [3:0] sel;
        sel = idx[3:0];
        return (idx < 16) ? RESET_DEFAULTS[sel] : 9'h000;
    endfunction

endpackage

// File: rtl/codec_i2c_target_if.sv
// Two-wire control bus as seen by the codec target; sda_oe=1 pulls SDA low.
interface codec_i2c_target_if;
    logic scl;
    logic sda;
    logic sda_oe;

    modport slave  (input scl, input sda, output sda_oe);
    modport master (output scl, output sda, input sda_oe);
endinterface

// File: rtl/codec_i2c_target_line_sync.sv
// SCL/SDA synchroniser with registered edge, START and STOP detection.
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o,
    output logic sda_s_o
);
    logic [SYNC_STAGES-1:0] scl_ff_q, sda_ff_q;
    logic scl_prev_q, sda_prev_q;
    logic scl_s, sda_s;

    assign scl_s = scl_ff_q[SYNC_STAGES-1];
    assign sda_s = sda_ff_q[SYNC_STAGES-1];

    // Chains reset to the idle-high bus level so release of reset creates no false edges.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_ff_q    <= '1;
            sda_ff_q    <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            scl_rise_o  <= 1'b0;
            scl_fall_o  <= 1'b0;
            start_det_o <= 1'b0;
            stop_det_o  <= 1'b0;
            sda_s_o     <= 1'b1;
        end else begin
            scl_ff_q    <= {scl_ff_q[SYNC_STAGES-2:0], scl_i};
            sda_ff_q    <= {sda_ff_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q  <= scl_s;
            sda_prev_q  <= sda_s;
            scl_rise_o  <= scl_s & ~scl_prev_q;
            scl_fall_o  <= ~scl_s & scl_prev_q;
            start_det_o <= scl_s & scl_prev_q & sda_prev_q & ~sda_s;
            stop_det_o  <= scl_s & scl_prev_q & ~sda_prev_q & sda_s;
            sda_s_o     <= sda_s;
        end
    end
endmodule

// File: rtl/codec_i2c_target.sv
// Write-only I2C register target of a WM8731-class codec with a readable register shadow.
module codec_i2c_target
    import audio_codec_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = CODEC_DEV_ADDR,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    codec_i2c_target_if.slave  i2c,
    output logic               reg_wr_o,
    output logic [6:0]         reg_addr_o,
    output logic [8:0]         reg_data_o,
    input  logic [3:0]         rd_addr_i,
    output logic [8:0]         rd_data_o,
    output logic               busy_o
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .scl_i       (i2c.scl),
        .sda_i       (i2c.sda),
        .scl_rise_o  (scl_rise),
        .scl_fall_o  (scl_fall),
        .start_det_o (start_det),
        .stop_det_o  (stop_det),
        .sda_s_o     (sda_s)
    );

    i2c_tgt_state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [8:0] wr_data_q, wr_data_d;
    logic       commit;
    logic       byte_done;
    logic [8:0] shadow_q [NUM_REGS];

    assign byte_done = scl_fall && (bit_cnt_q == 4'd8);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        commit    = 1'b0;
        // Bus conditions outrank bit sampling when they coincide with an SCL edge.
        if (!en_i || stop_det) begin
            state_d  = TgtIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = TgtAddr;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else begin
            if ((state_q == TgtAddr || state_q == TgtByte0 || state_q == TgtByte1)
                && scl_rise && bit_cnt_q != 4'd8) begin
                shift_d   = {shift_q[6:0], sda_s};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
            unique case (state_q)
                TgtAddr: if (byte_done) begin
                    bit_cnt_d = 4'd0;
                    if (shift_q == {DEV_ADDR, 1'b0}) begin
                        state_d  = TgtAddrAck;
                        sda_oe_d = 1'b1;
                    end else begin
                        state_d = TgtIgnore;
                    end
                end
                TgtByte0: if (byte_done) begin
                    bit_cnt_d    = 4'd0;
                    wr_addr_d    = shift_q[7:1];
                    wr_data_d[8] = shift_q[0];
                    state_d      = TgtAck0;
                    sda_oe_d     = 1'b1;
                end
                TgtByte1: if (byte_done) begin
                    bit_cnt_d = 4'd0;
                    if ({25'd0, wr_addr_q} < NUM_REGS) begin
                        wr_data_d[7:0] = shift_q;
                        state_d        = TgtAck1;
                        sda_oe_d       = 1'b1;
                    end else begin
                        state_d = TgtIgnore;
                    end
                end
                TgtAddrAck: if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    state_d  = TgtByte0;
                end
                TgtAck0: if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    state_d  = TgtByte1;
                end
                TgtAck1: if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    state_d  = TgtIgnore;
                    commit   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= TgtIdle;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_addr_q  <= 7'd0;
            wr_data_q  <= 9'd0;
            reg_wr_o   <= 1'b0;
            reg_addr_o <= 7'd0;
            reg_data_o <= 9'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            reg_wr_o   <= commit;
            if (commit) begin
                reg_addr_o <= wr_addr_q;
                reg_data_o <= wr_data_q;
            end
        end
    end

    // Writing the reset register reloads the whole shadow instead of storing data.
    always_ff @(posedge clk_i) begin
        if (rst_i || (commit && wr_addr_q == RegReset)) begin
            for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= reset_default(i);
        end else if (commit) begin
            shadow_q[wr_addr_q[AW-1:0]] <= wr_data_q;
        end
    end

    assign rd_data_o  = shadow_q[rd_addr_i];
    assign i2c.sda_oe = sda_oe_q;
    assign busy_o     = busy_q;
endmodule

// File: tb/tb_codec_i2c_target.sv
// Directed bench for codec_i2c_target: bit-banged I2C master with hand-computed expectations.
module tb_codec_i2c_target;
    localparam int Q = 20;

    logic       clk = 1'b0;
    logic       rst, en, m_sda;
    logic       reg_wr, busy;
    logic [6:0] reg_addr;
    logic [8:0] reg_data, rd_data;
    logic [3:0] rd_addr;
    logic       ack;
    int         vectors = 0;
    int         miscompares = 0;
    int         wr_count = 0;
    logic [8:0] defs [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                              9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};

    always #5 clk = ~clk;

    codec_i2c_target_if ifc ();
    assign ifc.sda = m_sda & ~ifc.sda_oe;

    codec_i2c_target dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .i2c        (ifc),
        .reg_wr_o   (reg_wr),
        .reg_addr_o (reg_addr),
        .reg_data_o (reg_data),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .busy_o     (busy)
    );

    always @(posedge clk) if (reg_wr) wr_count <= wr_count + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_rd(input string tag, input logic [3:0] a, input logic [8:0] exp);
        rd_addr = a;
        #1;
        check(tag, {23'd0, rd_data}, {23'd0, exp});
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(Q);
        ifc.scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        ifc.scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q);
        ifc.scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            m_sda = b[i]; tick(Q);
            ifc.scl = 1'b1; tick(Q);
            ifc.scl = 1'b0; tick(2);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic a);
        send_bits(b, 8);
        m_sda = 1'b1; tick(Q);
        ifc.scl = 1'b1; tick(Q / 2);
        a = (ifc.sda === 1'b0);
        tick(Q / 2);
        ifc.scl = 1'b0; tick(2);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; m_sda = 1'b1; ifc.scl = 1'b1; rd_addr = 4'd0;
        tick(4);
        rst = 1'b0;
        tick(1);
        check("rst_sda_oe", {31'd0, ifc.sda_oe}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_reg_wr", {31'd0, reg_wr}, 0);
        check("rst_reg_addr", {25'd0, reg_addr}, 0);
        check("rst_reg_data", {23'd0, reg_data}, 0);
        check_rd("rst_r0", 4'd0, 9'h097);
        check_rd("rst_r2", 4'd2, 9'h079);
        check_rd("rst_r15", 4'd15, 9'h000);

        // R4 = 0x012
        i2c_start();
        check("t1_busy_start", {31'd0, busy}, 1);
        send_byte(8'h34, ack); check("t1_ack_addr", {31'd0, ack}, 1);
        send_byte(8'h08, ack); check("t1_ack_b0", {31'd0, ack}, 1);
        send_byte(8'h12, ack); check("t1_ack_b1", {31'd0, ack}, 1);
        i2c_stop();
        check("t1_busy_stop", {31'd0, busy}, 0);
        check("t1_wr_count", wr_count, 1);
        check("t1_reg_addr", {25'd0, reg_addr}, 4);
        check("t1_reg_data", {23'd0, reg_data}, 9'h012);
        check_rd("t1_r4", 4'd4, 9'h012);

        // Wrong address, then correct address with read bit
        i2c_start();
        send_byte(8'h36, ack); check("t2_nack_1b", {31'd0, ack}, 0);
        send_byte(8'h08, ack); check("t2_nack_next", {31'd0, ack}, 0);
        check("t2_busy_mid", {31'd0, busy}, 1);
        i2c_stop();
        check("t2_busy_stop", {31'd0, busy}, 0);
        i2c_start();
        send_byte(8'h35, ack); check("t2_nack_read", {31'd0, ack}, 0);
        i2c_stop();
        check("t2_wr_count", wr_count, 1);
        check_rd("t2_r4", 4'd4, 9'h012);

        // R0 = 0x1FF, then reset register reloads defaults
        i2c_start();
        send_byte(8'h34, ack);
        send_byte(8'h01, ack);
        send_byte(8'hFF, ack); check("t3_ack_r0", {31'd0, ack}, 1);
        i2c_stop();
        check_rd("t3_r0_set", 4'd0, 9'h1FF);
        i2c_start();
        send_byte(8'h34, ack);
        send_byte(8'h1E, ack);
        send_byte(8'h00, ack); check("t3_ack_r15", {31'd0, ack}, 1);
        i2c_stop();
        check("t3_wr_count", wr_count, 3);
        check("t3_reg_addr", {25'd0, reg_addr}, 7'h0F);
        for (int i = 0; i < 10; i++) check_rd($sformatf("t3_def_r%0d", i), 4'(i), defs[i]);
        check_rd("t3_r15", 4'd15, 9'h000);

        // Out-of-range register 0x12
        i2c_start();
        send_byte(8'h34, ack);
        send_byte(8'h24, ack); check("t4_ack_b0", {31'd0, ack}, 1);
        send_byte(8'h55, ack); check("t4_nack_b1", {31'd0, ack}, 0);
        send_byte(8'h66, ack); check("t4_nack_b2", {31'd0, ack}, 0);
        i2c_stop();
        check("t4_wr_count", wr_count, 3);

        // STOP after byte0, then full write R7 = 0x04A
        i2c_start();
        send_byte(8'h34, ack);
        send_byte(8'h0E, ack); check("t5_ack_b0", {31'd0, ack}, 1);
        i2c_stop();
        check("t5_no_wr", wr_count, 3);
        check_rd("t5_r7_kept", 4'd7, 9'h00A);
        i2c_start();
        send_byte(8'h34, ack);
        send_byte(8'h0E, ack);
        send_byte(8'h4A, ack); check("t5_ack_b1", {31'd0, ack}, 1);
        i2c_stop();
        check("t5_wr_count", wr_count, 4);
        check("t5_reg_addr", {25'd0, reg_addr}, 7);
        check("t5_reg_data", {23'd0, reg_data}, 9'h04A);
        check_rd("t5_r7", 4'd7, 9'h04A);

        // Repeated START in the middle of byte1 discards the partial write
        i2c_start();
        send_byte(8'h34, ack);
        send_byte(8'h08, ack);
        send_bits(8'hFF, 4);
        i2c_start();
        check("t6_rs_oe", {31'd0, ifc.sda_oe}, 0);
        check("t6_rs_busy", {31'd0, busy}, 1);
        send_byte(8'h34, ack); check("t6_rs_ack", {31'd0, ack}, 1);
        send_byte(8'h0A, ack);
        send_byte(8'h55, ack);
        i2c_stop();
        check("t6_wr_count", wr_count, 5);
        check_rd("t6_r5", 4'd5, 9'h055);
        check_rd("t6_r4", 4'd4, 9'h00A);

        // rst_i pulse while the address ACK is driven
        i2c_start();
        send_bits(8'h34, 8);
        m_sda = 1'b1; tick(Q);
        check("t7_ack_driven", {31'd0, ifc.sda_oe}, 1);
        ifc.scl = 1'b1; tick(4);
        rst = 1'b1;
        tick(1);
        check("t7_rst_oe", {31'd0, ifc.sda_oe}, 0);
        check("t7_rst_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        check_rd("t7_r5_def", 4'd5, 9'h008);
        tick(Q);
        ifc.scl = 1'b0; tick(Q);
        i2c_stop();
        i2c_start();
        send_byte(8'h34, ack); check("t7_ack_addr", {31'd0, ack}, 1);
        send_byte(8'h0C, ack);
        send_byte(8'hAB, ack); check("t7_ack_b1", {31'd0, ack}, 1);
        i2c_stop();
        check("t7_wr_count", wr_count, 6);
        check_rd("t7_r6", 4'd6, 9'h0AB);

        // en_i low mid-transfer behaves like STOP
        i2c_start();
        send_byte(8'h34, ack);
        en = 1'b0; tick(2);
        check("t8_en_busy", {31'd0, busy}, 0);
        check("t8_en_oe", {31'd0, ifc.sda_oe}, 0);
        en = 1'b1;
        i2c_stop();
        check("t8_wr_count", wr_count, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
